// File: rtl/cache_pkg.sv
// Shared types and sizing for the cache block fill controller.
package cache_pkg;

    localparam int unsigned CACHE_WORDS_PER_BLOCK  = 8;
    localparam int unsigned CACHE_MEM_READ_LATENCY = 4;
    localparam int unsigned ADDR_W                 = 16;
    localparam int unsigned DATA_W                 = 16;
    localparam int unsigned OFFSET_W               = 3;
    localparam int unsigned CNT_W                  = OFFSET_W + 1;
    localparam int unsigned BASE_W                 = ADDR_W - OFFSET_W - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        DRAIN   = 2'd2
    } fill_state_e;

endpackage : cache_pkg

// File: rtl/cache_fill_fsm_if.sv
// Miss request, memory read and data/tag array write signals of the fill controller.
interface cache_fill_fsm_if;
    import cache_pkg::*;

    logic                miss_detected;
    logic [ADDR_W-1:0]   miss_address;
    logic                fsm_busy;
    logic                mem_enable;
    logic                mem_wr;
    logic [ADDR_W-1:0]   memory_address;
    logic [DATA_W-1:0]   memory_data;
    logic                memory_data_valid;
    logic                write_data_array;
    logic [OFFSET_W-1:0] fill_word_offset;
    logic [DATA_W-1:0]   fill_data;
    logic                write_tag_array;

    modport master (
        input  miss_detected, miss_address, memory_data, memory_data_valid,
        output fsm_busy, mem_enable, mem_wr, memory_address,
               write_data_array, fill_word_offset, fill_data, write_tag_array
    );

    modport slave (
        output miss_detected, miss_address, memory_data, memory_data_valid,
        input  fsm_busy, mem_enable, mem_wr, memory_address,
               write_data_array, fill_word_offset, fill_data, write_tag_array
    );

endinterface : cache_fill_fsm_if

// File: rtl/cache_fill_fsm_counter.sv
// Word offset counter: loadable 3-bit wrap value plus a step count that flags the final step.
module fill_word_counter
    import cache_pkg::*;
#(
    parameter int unsigned STEPS = CACHE_WORDS_PER_BLOCK
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [OFFSET_W-1:0] load_val_i,
    input  logic                inc_i,
    output logic [OFFSET_W-1:0] value_o,
    output logic                done_o
);

    logic [OFFSET_W-1:0] value_q, value_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_comb begin
        value_d = value_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            value_d = load_val_i;
            cnt_d   = '0;
        end else if (inc_i) begin
            value_d = value_q + OFFSET_W'(1);
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            cnt_q   <= '0;
        end else begin
            value_q <= value_d;
            cnt_q   <= cnt_d;
        end
    end

    assign value_o = value_q;
    // High while the current step is the STEPS-th since the last load.
    assign done_o  = (cnt_q == CNT_W'(STEPS - 1));

endmodule : fill_word_counter

// File: rtl/cache_fill_fsm.sv
// Cache block fill controller: issues one read per word of the missing block, writes returns.
// Optional build macro CACHE_FILL_CRITICAL_WORD_FIRST_EN starts both offsets at the missed word.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int unsigned WORDS_PER_BLOCK  = CACHE_WORDS_PER_BLOCK,
    parameter int unsigned MEM_READ_LATENCY = CACHE_MEM_READ_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    cache_fill_fsm_if.master  bus
);

    if (WORDS_PER_BLOCK < 1 || WORDS_PER_BLOCK > 8 || MEM_READ_LATENCY < 1) begin : g_param_check
        $error("cache_fill_fsm: WORDS_PER_BLOCK must be 1..8 and MEM_READ_LATENCY >= 1");
    end

    fill_state_e         state_q, state_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic [OFFSET_W-1:0] start_off;
    logic [OFFSET_W-1:0] issue_off, recv_off;
    logic                issue_done, recv_done;
    logic                start_c, issue_inc_c, recv_inc_c;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    logic unused_miss_lsb;
    assign start_off       = bus.miss_address[OFFSET_W:1];
    assign unused_miss_lsb = bus.miss_address[0];
`else
    logic unused_miss_lsb;
    assign start_off       = '0;
    assign unused_miss_lsb = ^bus.miss_address[OFFSET_W:0];
`endif

    fill_word_counter #(.STEPS(WORDS_PER_BLOCK)) u_issue_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (start_c),
        .load_val_i (start_off),
        .inc_i      (issue_inc_c),
        .value_o    (issue_off),
        .done_o     (issue_done)
    );

    fill_word_counter #(.STEPS(WORDS_PER_BLOCK)) u_recv_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (start_c),
        .load_val_i (start_off),
        .inc_i      (recv_inc_c),
        .value_o    (recv_off),
        .done_o     (recv_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    // Next state and strobes; everything is forced low while rst is asserted.
    always_comb begin
        state_d                = state_q;
        base_d                 = base_q;
        start_c                = 1'b0;
        issue_inc_c            = 1'b0;
        recv_inc_c             = 1'b0;
        bus.mem_enable         = 1'b0;
        bus.memory_address     = '0;
        bus.write_data_array   = 1'b0;
        bus.fill_word_offset   = '0;
        bus.fill_data          = '0;
        bus.write_tag_array    = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (bus.miss_detected) begin
                        state_d = REQUEST;
                        base_d  = bus.miss_address[ADDR_W-1:OFFSET_W+1];
                        start_c = 1'b1;
                    end
                end
                REQUEST: begin
                    bus.mem_enable     = 1'b1;
                    bus.memory_address = {base_q, issue_off, 1'b0};
                    issue_inc_c        = 1'b1;
                    if (issue_done) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    state_d = DRAIN;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // Returns are taken only during a fill; the last one closes the block.
            if (state_q != IDLE && bus.memory_data_valid) begin
                bus.write_data_array = 1'b1;
                bus.fill_word_offset = recv_off;
                bus.fill_data        = bus.memory_data;
                recv_inc_c           = 1'b1;
                if (recv_done) begin
                    bus.write_tag_array = 1'b1;
                    state_d             = IDLE;
                end
            end
        end
    end

    assign bus.mem_wr   = 1'b0;
    assign bus.fsm_busy = !rst && (state_q != IDLE);

endmodule : cache_fill_fsm

// File: tb/tb_cache_fill_fsm.sv
// Directed self-checking bench for cache_fill_fsm; memory returns are scheduled by the bench.
module tb_cache_fill_fsm;
    import cache_pkg::*;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    localparam bit CWF_EN = 1'b1;
`else
    localparam bit CWF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    cache_fill_fsm_if bus();

    cache_fill_fsm #(
        .WORDS_PER_BLOCK  (8),
        .MEM_READ_LATENCY (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {busy, mem_enable, mem_wr, memory_address, write_data_array, fill_word_offset, fill_data, write_tag_array}
    logic [39:0] obs_v;
    assign obs_v = {bus.fsm_busy, bus.mem_enable, bus.mem_wr, bus.memory_address,
                    bus.write_data_array, bus.fill_word_offset, bus.fill_data, bus.write_tag_array};

    function automatic logic [39:0] pack(input logic busy, input logic men, input logic [15:0] addr,
                                         input logic wda, input logic [2:0] off,
                                         input logic [15:0] data, input logic tag);
        return {busy, men, 1'b0, addr, wda, off, data, tag};
    endfunction

    function automatic logic [2:0] start_of(input logic [15:0] a);
        return CWF_EN ? a[3:1] : 3'd0;
    endfunction

    // Expected outputs in cycle k of a fill (k = 0 is the first request cycle, 12 is the IDLE after it).
    function automatic logic [39:0] fill_exp(input logic [15:0] addr, input int k, input logic [15:0] d);
        logic [2:0] s;
        logic       rq;
        logic       rx;
        s  = start_of(addr);
        rq = (k >= 0 && k <= 7);
        rx = (k >= 4 && k <= 11);
        return pack(k <= 11, rq, rq ? {addr[15:4], 3'(s + 3'(k)), 1'b0} : 16'h0,
                    rx, rx ? 3'(s + 3'(k - 4)) : 3'd0, rx ? d : 16'h0, k == 11);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r, input logic miss, input logic [15:0] maddr,
                          input logic vld, input logic [15:0] data);
        rst                   = r;
        bus.miss_detected     = miss;
        bus.miss_address      = maddr;
        bus.memory_data_valid = vld;
        bus.memory_data       = data;
        #1;
    endtask

    task automatic test_reset();
        set_in(1'b1, 1'b1, 16'h1236, 1'b1, 16'hBEEF);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            set_in(1'b1, 1'b1, 16'h1236, 1'b1, 16'hBEEF);
            tests_run++;
            if (obs_v !== 40'h0) begin
                tests_failed++;
                $display("FAIL reset_hold cycle %0d: got %h want %h", i, obs_v, 40'h0);
            end
        end
        next_cycle();
        set_in(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        tests_run++;
        if (obs_v !== 40'h0) begin
            tests_failed++;
            $display("FAIL reset_after: got %h want %h", obs_v, 40'h0);
        end
    endtask

    task automatic test_fill(input string name, input logic [15:0] addr);
        logic [15:0] d;
        set_in(1'b0, 1'b1, addr, 1'b0, 16'h0);
        tests_run++;
        if (obs_v !== 40'h0) begin
            tests_failed++;
            $display("FAIL %s idle_before: got %h want %h", name, obs_v, 40'h0);
        end
        for (int c = 0; c <= 12; c++) begin
            next_cycle();
            d = 16'hD000 + 16'(c);
            set_in(1'b0, c <= 11, addr, c >= 4 && c <= 11, d);
            tests_run++;
            if (obs_v !== fill_exp(addr, c, d)) begin
                tests_failed++;
                $display("FAIL %s cycle %0d: got %h want %h", name, c, obs_v, fill_exp(addr, c, d));
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [15:0] a;
        logic [15:0] d;
        a = 16'h1236;
        set_in(1'b0, 1'b1, a, 1'b0, 16'h0);
        for (int c = 0; c <= 5; c++) begin
            next_cycle();
            d = 16'hD000 + 16'(c);
            set_in(1'b0, 1'b1, a, c >= 4, d);
            if (c == 5) begin
                tests_run++;
                if (obs_v !== fill_exp(a, c, d)) begin
                    tests_failed++;
                    $display("FAIL mid_fill_pre cycle 5: got %h want %h", obs_v, fill_exp(a, c, d));
                end
            end
        end
        next_cycle();
        set_in(1'b1, 1'b0, a, 1'b1, 16'hD006);
        tests_run++;
        if (obs_v !== 40'h0) begin
            tests_failed++;
            $display("FAIL mid_fill_rst cycle 6: got %h want %h", obs_v, 40'h0);
        end
        next_cycle();
        set_in(1'b0, 1'b0, a, 1'b0, 16'h0);
        tests_run++;
        if (obs_v !== 40'h0) begin
            tests_failed++;
            $display("FAIL mid_fill_after cycle 7: got %h want %h", obs_v, 40'h0);
        end
        for (int c = 8; c <= 11; c++) begin
            next_cycle();
            set_in(1'b0, 1'b0, 16'h0, 1'b1, 16'hC000 + 16'(c));
            tests_run++;
            if (obs_v !== 40'h0) begin
                tests_failed++;
                $display("FAIL mid_fill_stray cycle %0d: got %h want %h", c, obs_v, 40'h0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a1;
        logic [15:0] a2;
        logic [15:0] d;
        logic [15:0] fa;
        int          k;
        a1 = 16'h1236;
        a2 = 16'h4440;
        set_in(1'b0, 1'b1, a1, 1'b0, 16'h0);
        for (int c = 0; c <= 25; c++) begin
            next_cycle();
            k  = (c <= 12) ? c : c - 13;
            fa = (c <= 12) ? a1 : a2;
            d  = 16'hE000 + 16'(c);
            set_in(1'b0, c <= 12, (c >= 5) ? a2 : a1, k >= 4 && k <= 11, d);
            tests_run++;
            if (obs_v !== fill_exp(fa, k, d)) begin
                tests_failed++;
                $display("FAIL back_to_back cycle %0d: got %h want %h", c, obs_v, fill_exp(fa, k, d));
            end
        end
    endtask

    task automatic test_idle_valid();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            set_in(1'b0, 1'b0, 16'h0, 1'b1, 16'hBEEF);
            tests_run++;
            if (obs_v !== 40'h0) begin
                tests_failed++;
                $display("FAIL idle_valid cycle %0d: got %h want %h", i, obs_v, 40'h0);
            end
        end
        set_in(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    initial begin
        rst                   = 1'b1;
        bus.miss_detected     = 1'b0;
        bus.miss_address      = 16'h0;
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = 16'h0;
        test_reset();
        test_fill(CWF_EN ? "fill_critical_first" : "fill_in_order", 16'h1236);
        test_reset_mid_fill();
        test_back_to_back();
        test_idle_valid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_cache_fill_fsm
